// File: rtl/magnitude_search.sv
// Binary search driver for an external magnitude comparator: presents midpoint
// probes, narrows [lo, hi] from eq/gt/lt answers, reports the located value.
module magnitude_search #(
  parameter int W = 4,
  localparam int CW = ($clog2(W + 2) < 3) ? 3 : $clog2(W + 2)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [W-1:0]  probe,
  output logic          probe_valid,
  input  logic          resp_valid,
  input  logic          resp_eq,
  input  logic          resp_gt,
  input  logic          resp_lt,
  output logic [W-1:0]  result,
  output logic [CW-1:0] probe_cnt,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    fsm_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PROBE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Handshake: a response is taken on a rising edge only when probe_valid and
  // resp_valid are both high; probe holds steady for as long as the responder stalls.

  logic [1:0]   state_q;
  logic [W:0]   lo_q;
  logic [W:0]   hi_q;       // two's complement, may reach -1 after an lt on probe 0
  logic [W:0]   sum;
  logic [W-1:0] mid;
  logic [W:0]   lo_nxt;
  logic [W:0]   hi_nxt;
  logic [W:0]   new_lo;
  logic [W:0]   new_hi;
  logic         one_hot;
  logic         crossed;

  // Inside PROBE both bounds are non-negative and lo <= hi, so the sum fits W+1 bits.
  assign sum     = lo_q + hi_q;
  assign mid     = sum[W:1];
  assign lo_nxt  = {1'b0, mid} + (W+1)'(1);
  assign hi_nxt  = {1'b0, mid} - (W+1)'(1);
  assign new_lo  = resp_gt ? lo_nxt : lo_q;
  assign new_hi  = resp_lt ? hi_nxt : hi_q;
  assign one_hot = $onehot({resp_eq, resp_gt, resp_lt});
  assign crossed = $signed({1'b0, new_lo}) > $signed({new_hi[W], new_hi});

  assign busy        = (state_q == PROBE);
  assign done        = (state_q == DONE);
  assign probe_valid = busy;
  assign probe       = busy ? mid : '0;
  assign fsm_state   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      result    <= '0;
      probe_cnt <= '0;
      err       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            lo_q      <= '0;
            hi_q      <= {1'b0, {W{1'b1}}};
            probe_cnt <= '0;
            err       <= 1'b0;
            state_q   <= PROBE;
          end
        end
        PROBE: begin
          if (resp_valid) begin
            probe_cnt <= probe_cnt + CW'(1);
            if (!one_hot) begin
              err     <= 1'b1;
              state_q <= DONE;
            end else if (resp_eq) begin
              result  <= mid;
              err     <= 1'b0;
              state_q <= DONE;
            end else begin
              lo_q <= new_lo;
              hi_q <= new_hi;
              if (crossed) begin
                err     <= 1'b1;
                state_q <= DONE;
              end
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_magnitude_search.sv
// Directed and randomized bench for magnitude_search (W=4) against a plain
// integer binary-search reference model and a stalling comparator responder.
module tb_magnitude_search;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] probe;
  logic         probe_valid;
  logic         resp_valid;
  logic         resp_eq;
  logic         resp_gt;
  logic         resp_lt;
  logic [W-1:0] result;
  logic [2:0]   probe_cnt;
  logic         busy;
  logic         done;
  logic         err;
  logic [1:0]   fsm_state;

  int vectors;
  int miscompares;
  int exp_result;
  logic [W-1:0] exp_q[$];

  magnitude_search #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .probe(probe), .probe_valid(probe_valid),
    .resp_valid(resp_valid), .resp_eq(resp_eq), .resp_gt(resp_gt), .resp_lt(resp_lt),
    .result(result), .probe_cnt(probe_cnt), .busy(busy), .done(done), .err(err),
    .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: the probe sequence an ideal binary search over 0..2^W-1 produces.
  // A target of 2^W models a responder that always answers gt.
  task automatic model(input int tgt, output bit found);
    int lo, hi, mid;
    lo = 0;
    hi = (1 << W) - 1;
    found = 0;
    exp_q.delete();
    while (lo <= hi) begin
      mid = (lo + hi) / 2;
      exp_q.push_back(W'(mid));
      if (tgt == mid) begin
        found = 1;
        break;
      end else if (tgt > mid) lo = mid + 1;
      else hi = mid - 1;
    end
  endtask

  task automatic junk_resp();
    resp_valid = 1'b0;
    resp_eq = 1'($urandom_range(0, 1));
    resp_gt = 1'($urandom_range(0, 1));
    resp_lt = 1'($urandom_range(0, 1));
  endtask

  // mode 0: truthful responder, 1: always gt, 2: gt and lt together
  task automatic run_search(input int target, input int max_stall, input int mode,
                            input bit start_at_done);
    int tgt, n, stall;
    bit found, exp_err;
    tgt = (mode == 1) ? (1 << W) : target;
    model(tgt, found);
    if (mode == 2) begin
      while (exp_q.size() > 1) void'(exp_q.pop_back());
      found = 0;
    end
    exp_err = !found;
    n = exp_q.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      stall = $urandom_range(0, max_stall);
      for (int s = 0; s < stall; s++) begin
        chk("stall_probe", 32'(probe), 32'(exp_q[i]));
        chk("stall_valid", 32'(probe_valid), 32'd1);
        chk("stall_cnt", 32'(probe_cnt), 32'(i));
        junk_resp();
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      chk("probe", 32'(probe), 32'(exp_q[i]));
      chk("busy", 32'(busy), 32'd1);
      start = 1'b0;
      resp_valid = 1'b1;
      if (mode == 2) begin
        resp_eq = 1'b0; resp_gt = 1'b1; resp_lt = 1'b1;
      end else begin
        resp_eq = (tgt == int'(exp_q[i]));
        resp_gt = (tgt >  int'(exp_q[i]));
        resp_lt = (tgt <  int'(exp_q[i]));
      end
      @(negedge clk);
      junk_resp();
    end
    if (!exp_err) exp_result = tgt;
    chk("done", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_pvalid", 32'(probe_valid), 32'd0);
    chk("err", 32'(err), 32'(exp_err));
    chk("cnt", 32'(probe_cnt), 32'(n));
    chk("result", 32'(result), 32'(exp_result));
    start = start_at_done;
    @(negedge clk);
    start = 1'b0;
    chk("after_done", 32'(done), 32'd0);
    chk("after_busy", 32'(busy), 32'd0);
    chk("after_result", 32'(result), 32'(exp_result));
    @(negedge clk);
    chk("not_queued", 32'(busy), 32'd0);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    exp_result = 0;
    rst_n = 1'b0;
    start = 1'b0;
    resp_valid = 1'b0;
    resp_eq = 1'b0; resp_gt = 1'b0; resp_lt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_probe", 32'(probe), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cnt", 32'(probe_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    resp_valid = 1'b1; resp_eq = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0; resp_eq = 1'b0;
    chk("idle_resp_busy", 32'(busy), 32'd0);
    chk("idle_resp_done", 32'(done), 32'd0);
    chk("idle_resp_cnt", 32'(probe_cnt), 32'd0);

    run_search(7, 0, 0, 0);
    run_search(0, 3, 0, 1);
    run_search(15, 0, 0, 0);
    run_search(5, 0, 2, 0);
    run_search(0, 1, 1, 1);
    for (int k = 0; k < 8; k++)
      run_search($urandom_range(0, (1 << W) - 1), $urandom_range(0, 3), 0,
                 1'($urandom_range(0, 1)));

    // asynchronous reset while waiting on probe 11
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rs_probe7", 32'(probe), 32'd7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    resp_valid = 1'b1; resp_eq = 1'b0; resp_gt = 1'b1; resp_lt = 1'b0;
    @(negedge clk);
    resp_valid = 1'b0; resp_gt = 1'b0;
    chk("rs_probe11", 32'(probe), 32'd11);
    chk("rs_cnt1", 32'(probe_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_pvalid", 32'(probe_valid), 32'd0);
    chk("ar_probe", 32'(probe), 32'd0);
    chk("ar_result", 32'(result), 32'd0);
    chk("ar_cnt", 32'(probe_cnt), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_err", 32'(err), 32'd0);
    exp_result = 0;
    @(negedge clk);
    rst_n = 1'b1;
    resp_valid = 1'b1; resp_eq = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0; resp_eq = 1'b0;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_cnt", 32'(probe_cnt), 32'd0);
    chk("post_rst_result", 32'(result), 32'd0);
    run_search(12, 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
